// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types and constants for the sequential multiplier
package mult_seq_pkg;

    localparam int DATA_W = 8;
    localparam int ITERS  = 8;
    localparam int CNT_W  = $clog2(ITERS);

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_OVF = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEST,
        ST_CARRY,
        ST_ADD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared 8-bit alu; opcode 3'b111 returns the carry-out of a+b in bit 0
module alu
    import mult_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        case (op)
            3'b000:  result = a & b;
            3'b001:  result = sum[DATA_W-1:0];
            3'b010:  result = a - b;
            3'b011:  result = a | b;
            3'b100:  result = a ^ b;
            3'b101:  result = a;
            3'b110:  result = b;
            3'b111:  result = {{(DATA_W-1){1'b0}}, sum[DATA_W]};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - 8x8 unsigned shift-and-add multiplier built around one shared alu
module mult_seq
    import mult_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     mult_a,
    input  logic [DATA_W-1:0]     mult_b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product,
    output logic                  zero
);

    state_t              state;
    state_t              state_nx;
    logic [DATA_W-1:0]   m;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                carry;
    logic [CNT_W-1:0]    count;
    logic [2:0]          alu_op;
    logic [DATA_W-1:0]   alu_out;
    logic [2*DATA_W-1:0] shift_val;
    logic                last_iter;

    // {carry, hi, lo} shifted right by one: the value hi/lo hold after SHIFT
    assign shift_val = {carry, hi, lo[DATA_W-1:1]};
    assign last_iter = (count == CNT_W'(ITERS - 1));

    alu u_alu (
        .a      (hi),
        .b      (m),
        .op     (alu_op),
        .result (alu_out),
        .zero   ()
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            carry   <= 1'b0;
            count   <= '0;
            product <= '0;
            zero    <= 1'b1;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m     <= mult_a;
                        lo    <= mult_b;
                        hi    <= '0;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                ST_CARRY: carry <= alu_out[0];
                ST_ADD:   hi    <= alu_out;
                ST_SHIFT: begin
                    hi    <= shift_val[2*DATA_W-1:DATA_W];
                    lo    <= shift_val[DATA_W-1:0];
                    carry <= 1'b0;
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        product <= shift_val;
                        zero    <= (shift_val == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = start ? ST_TEST : ST_IDLE;
            ST_TEST:  state_nx = lo[0] ? ST_CARRY : ST_SHIFT;
            ST_CARRY: state_nx = ST_ADD;
            ST_ADD:   state_nx = ST_SHIFT;
            ST_SHIFT: state_nx = last_iter ? ST_DONE : ST_TEST;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        done   = (state == ST_DONE);
        alu_op = (state == ST_CARRY) ? ALU_OVF : ALU_ADD;
    end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - scoreboard bench for mult_seq
module tb_mult_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] sb[$];
    logic        m_run  = 1'b0;
    int          m_left = 0;
    logic [15:0] m_prod = 16'h0000;

    mult_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mult_a  (mult_a),
        .mult_b  (mult_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference timing model: accept in IDLE, done 17+2*popcount(b) cycles later
    always @(posedge clk) begin
        if (reset) begin
            m_run  = 1'b0;
            m_left = 0;
            m_prod = 16'h0000;
            sb.delete();
        end else if (m_run) begin
            if (m_left == 0) begin
                m_run = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else m_prod = sb.pop_front();
                end
            end
        end else if (start) begin
            m_run  = 1'b1;
            m_left = 17 + 2 * $countones(mult_b) - 1;
            sb.push_back(16'(mult_a) * 16'(mult_b));
        end
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_run});
        chk("done", {31'd0, done}, {31'd0, (m_run && m_left == 0)});
        chk("product", {16'd0, product}, {16'd0, m_prod});
        chk("zero", {31'd0, zero}, {31'd0, (m_prod == 16'h0000)});
    end

    task automatic wait_idle();
        int guard = 0;
        while (m_run && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (m_run) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_prod, input int exp_lat, input string tag);
        int n;
        bit seen;
        wait_idle();
        start  = 1'b1;
        mult_a = a;
        mult_b = b;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        seen  = 1'b0;
        while (!seen && n <= 60) begin
            if (done) begin
                seen = 1'b1;
                chk({tag, "_lat"}, n, exp_lat);
                chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp_prod});
                chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_prod == 16'h0000)});
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [7:0] ra;
        logic [7:0] rb;

        reset  = 1'b1;
        start  = 1'b0;
        mult_a = 8'h00;
        mult_b = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_prod", {16'd0, product}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);

        // reset wins over a simultaneous start
        start = 1'b1;
        mult_a = 8'h33;
        mult_b = 8'h44;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        run(8'h00, 8'h00, 16'h0000, 17, "zero");
        run(8'hFF, 8'hFF, 16'hFE01, 33, "ffff");
        run(8'h0D, 8'h0B, 16'h008F, 23, "d_b");
        run(8'h02, 8'h80, 16'h0100, 19, "b2b");

        // start held high with changing operands while busy
        wait_idle();
        start  = 1'b1;
        mult_a = 8'h10;
        mult_b = 8'h10;
        pulses = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            if (m_run && !(m_left == 0)) begin
                start  = 1'b1;
                mult_a = 8'($urandom);
                mult_b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("spam_pulses", pulses, 32'd1);
        chk("spam_prod", {16'd0, product}, 32'h0100);

        // reset in cycle 5 of an operation
        wait_idle();
        start  = 1'b1;
        mult_a = 8'h7F;
        mult_b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_prod", {16'd0, product}, 32'd0);
        chk("mid_rst_zero", {31'd0, zero}, 32'd1);
        run(8'h7F, 8'h03, 16'h017D, 21, "after_rst");

        run(8'h01, 8'hFF, 16'h00FF, 33, "one_ff");
        run(8'hFF, 8'h01, 16'h00FF, 19, "ff_one");
        run(8'h00, 8'hFF, 16'h0000, 33, "zero_ff");

        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            run(ra, rb, 16'(ra) * 16'(rb), 17 + 2 * $countones(rb), "rand");
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
